mdio_responder: RTL and testbench

- Clause-22 MDIO management responder (PHY/target side): the far end of the EMAC's MDIO initiator.
- Oversamples MDC/MDIO on the system clock and decodes frames addressed to its PHY address.
- Translates read/write frames into single-cycle register strobes towards a local register file, and drives read data back onto MDIO.
- Sits beside the SGMII PCS and serves the PCS/PHY-emulation registers to the HPS EMAC MDIO master.

---
 rtl/mdio_pkg.sv | 11 +
 rtl/mdio_responder_if.sv | 16 +
 rtl/mdio_sync_edge.sv | 24 ++
 rtl/mdio_responder.sv | 146 ++++++++++++++
 tb/tb_mdio_responder.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: frame states, opcodes and field widths shared by the MDIO responder
package mdio_pkg;
    typedef enum logic [3:0] {IDLE, ST1, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP} state_t;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W = 16;
    localparam int FRAME_BITS = 32;
endpackage

// File: rtl/mdio_responder_if.sv
// mdio_responder_if: MDIO pins plus local register-file strobes of the responder
interface mdio_responder_if;
    import mdio_pkg::*;
    logic mdc_i, mdio_i, mdio_o, mdio_oe;
    logic [REGAD_W-1:0] reg_address;
    logic [DATA_W-1:0] reg_writedata, reg_readdata;
    logic reg_write, reg_read, busy, frame_err;
    modport master (
        output mdc_i, mdio_i, reg_readdata,
        input mdio_o, mdio_oe, reg_address, reg_writedata, reg_write, reg_read, busy, frame_err
    );
    modport slave (
        input mdc_i, mdio_i, reg_readdata,
        output mdio_o, mdio_oe, reg_address, reg_writedata, reg_write, reg_read, busy, frame_err
    );
endinterface

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: two-flop synchronisers for MDC/MDIO and a rising-edge strobe on synced MDC
module mdio_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdio_s,
    output logic mdc_rise
);
    logic [1:0] mdc_q, mdio_q;
    logic mdc_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mdc_q <= '0;
            mdio_q <= '0;
            mdc_d <= 1'b0;
        end else begin
            mdc_q <= {mdc_q[0], mdc_i};
            mdio_q <= {mdio_q[0], mdio_i};
            mdc_d <= mdc_q[1];
        end
    assign mdio_s = mdio_q[1];
    assign mdc_rise = mdc_q[1] & ~mdc_d;
endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: clause-22 MDIO target turning frames into single-cycle register strobes
module mdio_responder import mdio_pkg::*; #(
    parameter logic [4:0] PHY_ADDR = 5'h01,
    parameter int PREAMBLE_MIN = 32,
    parameter int RD_LATENCY = 2
) (
    input logic clk_clk,
    input logic reset_reset,
    mdio_responder_if.slave bus
);
    // cnt holds the frame index (ST0 = 0) of the bit sampled on the next mdc_rise
    localparam logic [4:0] OP_END = 5'd3;
    localparam logic [4:0] PHY_END = OP_END + 5'(PHYAD_W);
    localparam logic [4:0] REG_END = PHY_END + 5'(REGAD_W);
    localparam logic [4:0] TA_END = REG_END + 5'd2;
    localparam logic [4:0] LAST = 5'(FRAME_BITS - 1);
    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
    state_t state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [5:0] pre, pre_n;
    logic [DATA_W-1:0] sr, sr_n, sh, wdata_n;
    logic [REGAD_W-1:0] addr_n;
    logic [1:0] op, op_n;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic mdo_n, oe_n, wr_n, rd_n, err_n, mdio_s, mdc_rise;

    mdio_sync_edge u_sync (
        .clk(clk_clk), .rst(reset_reset), .mdc_i(bus.mdc_i), .mdio_i(bus.mdio_i),
        .mdio_s(mdio_s), .mdc_rise(mdc_rise)
    );

    assign sh = {sr[DATA_W-2:0], mdio_s};
    assign bus.busy = !(state inside {IDLE, ST1});

    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) begin
            state <= IDLE;
            cnt <= '0;
            pre <= '0;
            sr <= '0;
            op <= '0;
            rd_pipe <= '0;
            bus.mdio_o <= 1'b0;
            bus.mdio_oe <= 1'b0;
            bus.reg_address <= '0;
            bus.reg_writedata <= '0;
            bus.reg_write <= 1'b0;
            bus.reg_read <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            pre <= pre_n;
            sr <= sr_n;
            op <= op_n;
            rd_pipe <= RD_LATENCY'({rd_pipe, bus.reg_read});
            bus.mdio_o <= mdo_n;
            bus.mdio_oe <= oe_n;
            bus.reg_address <= addr_n;
            bus.reg_writedata <= wdata_n;
            bus.reg_write <= wr_n;
            bus.reg_read <= rd_n;
            bus.frame_err <= err_n;
        end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        pre_n = pre;
        sr_n = sr;
        op_n = op;
        mdo_n = bus.mdio_o;
        oe_n = bus.mdio_oe;
        addr_n = bus.reg_address;
        wdata_n = bus.reg_writedata;
        wr_n = 1'b0;
        rd_n = 1'b0;
        err_n = 1'b0;
        if (mdc_rise) begin
            cnt_n = cnt + 5'd1;
            case (state)
                IDLE: begin
                    pre_n = mdio_s ? (pre >= PRE_MIN ? pre : pre + 6'd1) : 6'd0;
                    cnt_n = 5'd1;
                    state_n = !mdio_s && pre >= PRE_MIN ? ST1 : IDLE;
                end
                ST1: state_n = mdio_s ? OP : IDLE;
                OP: begin
                    sr_n = sh;
                    op_n = sh[1:0];
                    if (cnt == OP_END) state_n = sh[1:0] == OP_READ || sh[1:0] == OP_WRITE ? PHYAD : SKIP;
                end
                PHYAD: begin
                    sr_n = sh;
                    if (cnt == PHY_END) state_n = sh[4:0] == PHY_ADDR ? REGAD : SKIP;
                end
                REGAD: begin
                    sr_n = sh;
                    if (cnt == REG_END) begin
                        addr_n = sh[4:0];
                        rd_n = op == OP_READ;
                        state_n = TA;
                    end
                end
                TA:
                    if (op == OP_READ) begin
                        oe_n = 1'b1;
                        mdo_n = cnt == TA_END ? sr[DATA_W-1] : 1'b0;
                        sr_n = cnt == TA_END ? sr << 1 : sr;
                        state_n = cnt == TA_END ? RDATA : TA;
                    end else begin
                        sr_n = sh;
                        err_n = cnt == TA_END && sh[1:0] != TA_WRITE;
                        state_n = cnt != TA_END ? TA : err_n ? SKIP : WDATA;
                    end
                RDATA:
                    if (cnt == LAST) begin
                        oe_n = 1'b0;
                        mdo_n = 1'b0;
                        pre_n = '0;
                        state_n = IDLE;
                    end else begin
                        mdo_n = sr[DATA_W-1];
                        sr_n = sr << 1;
                    end
                WDATA: begin
                    sr_n = sh;
                    if (cnt == LAST) begin
                        wdata_n = sh;
                        wr_n = 1'b1;
                        pre_n = '0;
                        state_n = IDLE;
                    end
                end
                SKIP:
                    if (cnt == LAST) begin
                        pre_n = '0;
                        state_n = IDLE;
                    end
                default: state_n = IDLE;
            endcase
        end
        // read data lands well before the second TA bit, so it may simply overwrite the shifter
        if (rd_pipe[RD_LATENCY-1]) sr_n = bus.reg_readdata;
    end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed and random MDIO frames checked against a register-file model
module tb_mdio_responder;
    import mdio_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic mdc = 1'b0, mdio_drv = 1'b1, sel1 = 1'b0;
    always #5 clk = ~clk;

    mdio_responder_if if0 ();
    mdio_responder_if if1 ();
    mdio_responder #(.PHY_ADDR(5'h01), .PREAMBLE_MIN(32), .RD_LATENCY(2)) dut0 (
        .clk_clk(clk), .reset_reset(rst), .bus(if0));
    mdio_responder #(.PHY_ADDR(5'h01), .PREAMBLE_MIN(0), .RD_LATENCY(2)) dut1 (
        .clk_clk(clk), .reset_reset(rst), .bus(if1));

    logic [15:0] mem [32];
    logic [2:0] hist = '0;
    logic [4:0] rd_a = '0, wr_a = '0, wr1_a = '0;
    logic [15:0] wr_d = '0, wr1_d = '0;
    int wr_c = 0, rd_c = 0, err_c = 0, busy_c = 0, wr1_c = 0;
    int n_chk = 0, n_fail = 0;

    assign if0.mdc_i = sel1 ? 1'b0 : mdc;
    assign if1.mdc_i = sel1 ? mdc : 1'b0;
    assign if0.mdio_i = if0.mdio_oe ? if0.mdio_o : mdio_drv;
    assign if1.mdio_i = mdio_drv;
    // register-file stub: data is only valid in the one cycle RD_LATENCY after the read strobe
    assign if0.reg_readdata = hist[2] ? mem[rd_a] : 16'hDEAD;
    assign if1.reg_readdata = '0;

    always @(negedge clk) begin
        hist = {hist[1:0], if0.reg_read};
        if (if0.reg_read) begin rd_c++; rd_a = if0.reg_address; end
        if (if0.reg_write) begin wr_c++; wr_a = if0.reg_address; wr_d = if0.reg_writedata; end
        if (if0.frame_err) err_c++;
        if (if0.busy) busy_c++;
        if (if1.reg_write) begin wr1_c++; wr1_a = if1.reg_address; wr1_d = if1.reg_writedata; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_bit(input logic b, output logic line, output logic oe);
        mdio_drv = b;
        repeat (6) @(negedge clk);
        mdc = 1'b1;
        line = if0.mdio_oe ? if0.mdio_o : mdio_drv;
        oe = if0.mdio_oe;
        repeat (6) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [1:0] ta, input logic [15:0] d, input int abort_at);
        int pmin, s_wr, s_rd, s_err, s_busy, s_wr1, oe_rises;
        bit pre_ok, acc, is_rd, is_wr, is_err;
        logic [31:0] bits;
        logic [16:0] rd_bits;
        logic l, o;
        pmin = sel1 ? 0 : 32;
        pre_ok = npre >= pmin;
        acc = pre_ok && phy == 5'h01 && (op == OP_READ || op == OP_WRITE);
        is_rd = acc && op == OP_READ;
        is_wr = acc && op == OP_WRITE && ta == 2'b10;
        is_err = acc && op == OP_WRITE && ta != 2'b10;
        s_wr = wr_c; s_rd = rd_c; s_err = err_c; s_busy = busy_c; s_wr1 = wr1_c;
        oe_rises = 0;
        rd_bits = '0;
        bits = {2'b01, op, phy, ra, op == OP_READ ? 2'b11 : ta, op == OP_READ ? 16'hFFFF : d};
        for (int i = 0; i < npre; i++) clk_bit(1'b1, l, o);
        for (int i = 0; i < 32; i++) begin
            if (i == abort_at) begin
                check("oe_before_rst", 32'(if0.mdio_oe), 32'd1);
                @(negedge clk);
                rst = 1'b1;
                #1;
                check("rst_outs", 32'({if0.mdio_o, if0.mdio_oe, if0.reg_write, if0.reg_read, if0.busy, if0.frame_err}), 32'd0);
                check("rst_addr", 32'(if0.reg_address), 32'd0);
                check("rst_wdata", 32'(if0.reg_writedata), 32'd0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                mdio_drv = 1'b1;
                return;
            end
            clk_bit(bits[31-i], l, o);
            if (o) begin oe_rises++; rd_bits = {rd_bits[15:0], l}; end
        end
        mdio_drv = 1'b1;
        repeat (6) @(negedge clk);
        if (sel1) begin
            check("wr1_cnt", 32'(wr1_c - s_wr1), 32'(is_wr));
            if (is_wr) begin
                check("wr1_addr", 32'(wr1_a), 32'(ra));
                check("wr1_data", 32'(wr1_d), 32'(d));
            end
        end else begin
            check("wr_cnt", 32'(wr_c - s_wr), 32'(is_wr));
            check("rd_cnt", 32'(rd_c - s_rd), 32'(is_rd));
            check("err_cnt", 32'(err_c - s_err), 32'(is_err));
            check("oe_rises", 32'(oe_rises), is_rd ? 32'd17 : 32'd0);
            check("busy_seen", 32'(busy_c != s_busy), 32'(pre_ok));
            check("idle_after", 32'({if0.busy, if0.mdio_oe}), 32'd0);
            if (is_rd) begin
                check("rd_addr", 32'(rd_a), 32'(ra));
                check("rd_bits", 32'(rd_bits), 32'({1'b0, mem[ra]}));
            end
            if (is_wr) begin
                check("wr_addr", 32'(wr_a), 32'(ra));
                check("wr_data", 32'(wr_d), 32'(d));
                mem[ra] = d;
            end
        end
    endtask

    initial begin
        int kind;
        logic [1:0] op, ta;
        logic [4:0] phy, ra;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        mem[2] = 16'h1234;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({if0.mdio_o, if0.mdio_oe, if0.reg_write, if0.reg_read, if0.busy, if0.frame_err}), 32'd0);
        check("reset_addr_data", 32'({if0.reg_address, if0.reg_writedata}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        frame(32, 2'b01, 5'h01, 5'd4, 2'b10, 16'hA5C3, -1);
        frame(32, 2'b10, 5'h01, 5'd2, 2'b11, 16'h0000, -1);
        frame(32, 2'b10, 5'h03, 5'd2, 2'b11, 16'h0000, -1);
        frame(32, 2'b10, 5'h01, 5'd4, 2'b11, 16'h0000, -1);
        frame(31, 2'b01, 5'h01, 5'd5, 2'b10, 16'hBEEF, -1);
        sel1 = 1'b1;
        frame(0, 2'b01, 5'h01, 5'd6, 2'b10, 16'h5A5A, -1);
        sel1 = 1'b0;
        frame(32, 2'b01, 5'h01, 5'd7, 2'b11, 16'h0F0F, -1);
        frame(32, 2'b10, 5'h01, 5'd2, 2'b11, 16'h0000, 24);
        frame(32, 2'b10, 5'h01, 5'd2, 2'b11, 16'h0000, -1);
        for (int k = 0; k < 16; k++) begin
            kind = int'($urandom_range(0, 3));
            ra = 5'($urandom_range(0, 31));
            phy = kind == 3 ? 5'($urandom_range(2, 31)) : 5'h01;
            op = kind == 0 ? OP_WRITE : kind == 2 ? ($urandom_range(0, 1) == 1 ? 2'b00 : 2'b11) : OP_READ;
            ta = $urandom_range(0, 4) == 0 ? 2'($urandom_range(0, 1)) : 2'b10;
            frame(32 + int'($urandom_range(0, 8)), op, phy, ra, ta, 16'($urandom), -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
